// File: rtl/dmem_axi_master_pkg.sv
// dmem_axi_master_pkg: FSM state encoding, AXI4 burst/size/response constants
// and the datapath width shared by the data-memory AXI master.
package dmem_axi_master_pkg;

  localparam int data_size = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_BYTE  = 3'b000;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AxSIZE encoding for a word (4-byte) or byte access.
  function automatic logic [2:0] axi_size(input logic word);
    if (word) begin
      return SIZE_WORD;
    end else begin
      return SIZE_BYTE;
    end
  endfunction

endpackage

// File: rtl/dmem_axi_master_if.sv
// dmem_axi_master_if: the five AXI4 channels of the CPU data port.
// The master modport is used by dmem_axi_master, the slave modport by the
// interconnect side.
interface dmem_axi_master_if #(
  parameter int data_size = 32,
  parameter int ID_W      = 4
);
  logic [ID_W-1:0]        ARID;
  logic [data_size-1:0]   ARADDR;
  logic [7:0]             ARLEN;
  logic [2:0]             ARSIZE;
  logic [1:0]             ARBURST;
  logic                   ARVALID;
  logic                   ARREADY;

  logic [ID_W-1:0]        RID;
  logic [data_size-1:0]   RDATA;
  logic [1:0]             RRESP;
  logic                   RLAST;
  logic                   RVALID;
  logic                   RREADY;

  logic [ID_W-1:0]        AWID;
  logic [data_size-1:0]   AWADDR;
  logic [7:0]             AWLEN;
  logic [2:0]             AWSIZE;
  logic [1:0]             AWBURST;
  logic                   AWVALID;
  logic                   AWREADY;

  logic [data_size-1:0]   WDATA;
  logic [data_size/8-1:0] WSTRB;
  logic                   WLAST;
  logic                   WVALID;
  logic                   WREADY;

  logic [ID_W-1:0]        BID;
  logic [1:0]             BRESP;
  logic                   BVALID;
  logic                   BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering between the core and the 32-bit bus.
// Stores: byte data is replicated on every lane and a one-hot strobe picks the
// target lane. Loads: the addressed byte lane is selected and sign-extended.
module dmem_lane_align #(
  parameter int data_size = 32
) (
  input  logic [1:0]             st_lane,
  input  logic                   st_word,
  input  logic [data_size-1:0]   st_data,
  output logic [data_size/8-1:0] st_strb,
  output logic [data_size-1:0]   st_wdata,
  input  logic [1:0]             ld_lane,
  input  logic                   ld_word,
  input  logic [data_size-1:0]   ld_rdata,
  output logic [data_size-1:0]   ld_data
);
  localparam int NB = data_size / 8;

  logic [7:0] ld_byte_s;

  // Store lane steering: full word passes through, a byte goes to all lanes.
  always_comb begin
    if (st_word) begin
      st_strb  = {NB{1'b1}};
      st_wdata = st_data;
    end else begin
      st_strb  = {{(NB-1){1'b0}}, 1'b1} << st_lane;
      st_wdata = {NB{st_data[7:0]}};
    end
  end

  // Load byte select from the addressed lane.
  always_comb begin
    case (ld_lane)
      2'd0:    ld_byte_s = ld_rdata[7:0];
      2'd1:    ld_byte_s = ld_rdata[15:8];
      2'd2:    ld_byte_s = ld_rdata[23:16];
      2'd3:    ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = ld_rdata[7:0];
    endcase
  end

  // Load result: word unchanged, byte sign-extended.
  always_comb begin
    if (ld_word) begin
      ld_data = ld_rdata;
    end else begin
      ld_data = {{(data_size-8){ld_byte_s[7]}}, ld_byte_s};
    end
  end
endmodule

// File: rtl/dmem_axi_master.sv
// dmem_axi_master: converts the EX/MEM load/store request into a single-beat
// AXI4 read or write and holds the pipeline with stall until the response.
// Optional feature macro: DMEM_ERR_FLAG_EN enables the sticky bus_err flag
// (non-OKAY response or foreign ID); without it bus_err is tied low.
module dmem_axi_master #(
  parameter int              data_size = dmem_axi_master_pkg::data_size,
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MST_ID    = 4'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_memread,
  input  logic                 mem_memwrite,
  input  logic [data_size-1:0] addr,
  input  logic [data_size-1:0] wdata_in,
  input  logic                 ls_word,
  output logic [data_size-1:0] rdata_out,
  output logic                 stall,
  output logic                 bus_err,
  dmem_axi_master_if.master    bus
);
  import dmem_axi_master_pkg::*;

  localparam int NB = data_size / 8;

  state_t               state_r, state_s;
  logic                 arvalid_r, arvalid_s;
  logic                 rready_r, rready_s;
  logic                 awvalid_r, awvalid_s;
  logic                 wvalid_r, wvalid_s;
  logic                 bready_r, bready_s;
  logic [data_size-1:0] addr_r;
  logic [data_size-1:0] wdata_r;
  logic [NB-1:0]        wstrb_r;
  logic                 word_r;
  logic [data_size-1:0] rdata_r;

  logic                 req_s;
  logic                 aw_ok_s;
  logic                 w_ok_s;
  logic                 latch_s;
  logic                 rcap_s;
  logic                 bcap_s;
  logic                 stall_s;
  logic [NB-1:0]        st_strb_s;
  logic [data_size-1:0] st_wdata_s;
  logic [data_size-1:0] ld_data_s;

  assign req_s   = mem_memread | mem_memwrite;
  // A write channel is finished once its VALID has dropped or handshakes now.
  assign aw_ok_s = ~awvalid_r | bus.AWREADY;
  assign w_ok_s  = ~wvalid_r | bus.WREADY;

  dmem_lane_align #(.data_size(data_size)) u_lane_align (
    .st_lane  (addr[1:0]),
    .st_word  (ls_word),
    .st_data  (wdata_in),
    .st_strb  (st_strb_s),
    .st_wdata (st_wdata_s),
    .ld_lane  (addr_r[1:0]),
    .ld_word  (word_r),
    .ld_rdata (bus.RDATA),
    .ld_data  (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode; a simultaneous read and write request is a write.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_memwrite) begin
          state_s = WR_REQ;
        end else if (mem_memread) begin
          state_s = RD_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ADDR: begin
        if (arvalid_r && bus.ARREADY) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rready_r && bus.RVALID) begin
          state_s = DONE;
        end else begin
          state_s = RD_DATA;
        end
      end
      WR_REQ: begin
        if (aw_ok_s && w_ok_s) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        if (bready_r && bus.BVALID) begin
          state_s = DONE;
        end else begin
          state_s = WR_RESP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode: stall plus next values of the registered VALID/READY.
  always_comb begin
    stall_s   = 1'b0;
    latch_s   = 1'b0;
    rcap_s    = 1'b0;
    bcap_s    = 1'b0;
    arvalid_s = (state_s == RD_ADDR);
    rready_s  = (state_s == RD_DATA);
    bready_s  = (state_s == WR_RESP);
    awvalid_s = 1'b0;
    wvalid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = req_s;
        latch_s = req_s;
        if (state_s == WR_REQ) begin
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
        end else begin
          awvalid_s = 1'b0;
          wvalid_s  = 1'b0;
        end
      end
      RD_ADDR: stall_s = 1'b1;
      RD_DATA: begin
        stall_s = 1'b1;
        rcap_s  = rready_r & bus.RVALID;
      end
      WR_REQ: begin
        stall_s   = 1'b1;
        awvalid_s = awvalid_r & ~bus.AWREADY;
        wvalid_s  = wvalid_r & ~bus.WREADY;
      end
      WR_RESP: begin
        stall_s = 1'b1;
        bcap_s  = bready_r & bus.BVALID;
      end
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // Registered channel controls, latched request fields and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      addr_r    <= {data_size{1'b0}};
      wdata_r   <= {data_size{1'b0}};
      wstrb_r   <= {NB{1'b0}};
      word_r    <= 1'b0;
      rdata_r   <= {data_size{1'b0}};
    end else begin
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      awvalid_r <= awvalid_s;
      wvalid_r  <= wvalid_s;
      bready_r  <= bready_s;
      if (latch_s) begin
        addr_r  <= addr;
        word_r  <= ls_word;
        wdata_r <= st_wdata_s;
        wstrb_r <= st_strb_s;
      end
      if (rcap_s) begin
        rdata_r <= ld_data_s;
      end
    end
  end

  assign stall       = stall_s;
  assign rdata_out   = rdata_r;

  assign bus.ARID    = MST_ID;
  assign bus.ARADDR  = addr_r;
  assign bus.ARLEN   = 8'd0;
  assign bus.ARSIZE  = axi_size(word_r);
  assign bus.ARBURST = BURST_INCR;
  assign bus.ARVALID = arvalid_r;
  assign bus.RREADY  = rready_r;

  assign bus.AWID    = MST_ID;
  assign bus.AWADDR  = addr_r;
  assign bus.AWLEN   = 8'd0;
  assign bus.AWSIZE  = axi_size(word_r);
  assign bus.AWBURST = BURST_INCR;
  assign bus.AWVALID = awvalid_r;

  assign bus.WDATA   = wdata_r;
  assign bus.WSTRB   = wstrb_r;
  assign bus.WLAST   = 1'b1;
  assign bus.WVALID  = wvalid_r;
  assign bus.BREADY  = bready_r;

`ifdef DMEM_ERR_FLAG_EN
  logic bus_err_r;
  logic err_hit_s;
  logic unused_s;

  assign unused_s = bus.RLAST;

  // Flag a completed response carrying an error code or a foreign ID.
  always_comb begin
    err_hit_s = 1'b0;
    if (rcap_s && ((bus.RRESP != RESP_OKAY) || (bus.RID != MST_ID))) begin
      err_hit_s = 1'b1;
    end else if (bcap_s && ((bus.BRESP != RESP_OKAY) || (bus.BID != MST_ID))) begin
      err_hit_s = 1'b1;
    end else begin
      err_hit_s = 1'b0;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_r <= 1'b0;
    end else if (err_hit_s) begin
      bus_err_r <= 1'b1;
    end
  end

  assign bus_err = bus_err_r;
`else
  logic unused_s;

  assign unused_s = ^{bus.RLAST, bus.RID, bus.RRESP, bus.BID, bus.BRESP, bcap_s};
  assign bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_axi_master.sv
// tb_dmem_axi_master: scenario tasks drive the EX/MEM request and act as the
// AXI slave; expected bus fields and load results are queued at request time
// and popped when the DUT handshakes or completes.
`timescale 1ns/1ps
module tb_dmem_axi_master;
  localparam int         DW  = 32;
  localparam int         IW  = 4;
  localparam logic [3:0] MID = 4'd1;

  logic          clk;
  logic          rst;
  logic          mem_memread;
  logic          mem_memwrite;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata_in;
  logic          ls_word;
  logic [DW-1:0] rdata_out;
  logic          stall;
  logic          bus_err;

  dmem_axi_master_if #(.data_size(DW), .ID_W(IW)) bus ();

  dmem_axi_master #(.data_size(DW), .ID_W(IW), .MST_ID(MID)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .addr         (addr),
    .wdata_in     (wdata_in),
    .ls_word      (ls_word),
    .rdata_out    (rdata_out),
    .stall        (stall),
    .bus_err      (bus_err),
    .bus          (bus)
  );

  typedef struct packed { logic [31:0] a; logic [2:0] size; } req_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = 32'd0;
  req_t        exp_ar_q[$];
  req_t        exp_aw_q[$];
  beat_t       exp_w_q[$];
  logic [31:0] exp_rd_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    bus.ARREADY  = 1'b0;
    bus.RVALID   = 1'b0;
    bus.AWREADY  = 1'b0;
    bus.WREADY   = 1'b0;
    bus.BVALID   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY, stall, bus_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.BREADY, stall, bus_err});
    end
    checks++;
    if (rdata_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", rdata_out);
    end
    checks++;
    if ({bus.ARADDR, bus.AWADDR, bus.WDATA, bus.WSTRB} !== 100'd0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h %h %h %h expected zeros", bus.ARADDR, bus.AWADDR, bus.WDATA, bus.WSTRB);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic w, input logic [31:0] bdata,
                         input int ar_wait, input int r_wait, input logic [1:0] resp,
                         input logic [31:0] exp_val, input int exp_stall);
    int          stall_cnt = 0;
    int          wcnt = 0;
    int          cyc = 0;
    bit          ar_hs = 0;
    bit          done = 0;
    req_t        e;
    logic [31:0] ev;
    e.a    = a;
    e.size = w ? 3'b010 : 3'b000;
    exp_ar_q.push_back(e);
    exp_rd_q.push_back(exp_val);
    mem_memread  = 1'b1;
    mem_memwrite = 1'b0;
    addr         = a;
    ls_word      = w;
    wdata_in     = $urandom;
    while (!done && cyc < 60) begin
      #1;
      if (stall) begin
        stall_cnt++;
        if (bus.ARVALID && !ar_hs) begin
          if (wcnt >= ar_wait) begin
            bus.ARREADY = 1'b1;
            ar_hs = 1;
            wcnt = 0;
            e = exp_ar_q.pop_front();
            checks++;
            if (bus.ARADDR !== e.a || bus.ARSIZE !== e.size || bus.ARLEN !== 8'd0 ||
                bus.ARBURST !== 2'b01 || bus.ARID !== MID) begin
              errors++;
              $display("FAIL ar_fields: got addr %h size %0d len %0d burst %0d id %0d expected addr %h size %0d len 0 burst 1 id %0d",
                       bus.ARADDR, bus.ARSIZE, bus.ARLEN, bus.ARBURST, bus.ARID, e.a, e.size, MID);
            end
          end else begin
            bus.ARREADY = 1'b0;
            wcnt++;
          end
        end else begin
          bus.ARREADY = 1'b0;
        end
        if (bus.RREADY) begin
          if (wcnt >= r_wait) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = bdata;
            bus.RRESP  = resp;
          end else begin
            bus.RVALID = 1'b0;
            wcnt++;
          end
        end else begin
          bus.RVALID = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end else begin
        done = 1;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        mem_memread = 1'b0;
        checks++;
        if (stall_cnt != exp_stall) begin
          errors++;
          $display("FAIL load_stall_cycles addr %h: got %0d expected %0d", a, stall_cnt, exp_stall);
        end
        ev = exp_rd_q.pop_front();
        checks++;
        if (rdata_out !== ev) begin
          errors++;
          $display("FAIL load_data addr %h: got %h expected %h", a, rdata_out, ev);
        end
        last_load = ev;
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL load_timeout addr %h: got no completion expected completion within 60 cycles", a);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      last_load = 32'd0;
      @(negedge clk);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic w, input logic [31:0] d, input bit rd_too,
                          input int aw_wait, input int w_wait, input int b_wait, input logic [1:0] resp,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input int exp_stall);
    int    stall_cnt = 0;
    int    awc = 0;
    int    wc = 0;
    int    bc = 0;
    int    b_hs = 0;
    int    cyc = 0;
    bit    aw_hs = 0;
    bit    w_hs = 0;
    bit    w_seen = 0;
    bit    ar_seen = 0;
    bit    done = 0;
    req_t  e;
    beat_t b;
    e.a    = a;
    e.size = w ? 3'b010 : 3'b000;
    b.data = exp_wdata;
    b.strb = exp_strb;
    exp_aw_q.push_back(e);
    exp_w_q.push_back(b);
    mem_memwrite = 1'b1;
    mem_memread  = rd_too;
    addr         = a;
    ls_word      = w;
    wdata_in     = d;
    while (!done && cyc < 60) begin
      #1;
      if (stall) begin
        stall_cnt++;
        if (bus.ARVALID) ar_seen = 1;
        if (aw_hs || w_hs) begin
          checks++;
          if ((aw_hs && bus.AWVALID !== 1'b0) || (w_hs && bus.WVALID !== 1'b0)) begin
            errors++;
            $display("FAIL valid_drop_after_hs addr %h: got awvalid %b wvalid %b expected 0 after handshake",
                     a, bus.AWVALID, bus.WVALID);
          end
        end
        if (w_seen && !w_hs) begin
          checks++;
          if (bus.WVALID !== 1'b1) begin
            errors++;
            $display("FAIL wvalid_hold addr %h: got %b expected 1 until WREADY", a, bus.WVALID);
          end
        end
        if (bus.AWVALID && !aw_hs) begin
          if (awc >= aw_wait) begin
            bus.AWREADY = 1'b1;
            aw_hs = 1;
            e = exp_aw_q.pop_front();
            checks++;
            if (bus.AWADDR !== e.a || bus.AWSIZE !== e.size || bus.AWLEN !== 8'd0 ||
                bus.AWBURST !== 2'b01 || bus.AWID !== MID) begin
              errors++;
              $display("FAIL aw_fields: got addr %h size %0d len %0d burst %0d id %0d expected addr %h size %0d len 0 burst 1 id %0d",
                       bus.AWADDR, bus.AWSIZE, bus.AWLEN, bus.AWBURST, bus.AWID, e.a, e.size, MID);
            end
          end else begin
            bus.AWREADY = 1'b0;
            awc++;
          end
        end else begin
          bus.AWREADY = 1'b0;
        end
        if (bus.WVALID && !w_hs) begin
          w_seen = 1;
          if (wc >= w_wait) begin
            bus.WREADY = 1'b1;
            w_hs = 1;
            b = exp_w_q.pop_front();
            checks++;
            if (bus.WDATA !== b.data || bus.WSTRB !== b.strb || bus.WLAST !== 1'b1) begin
              errors++;
              $display("FAIL w_beat addr %h: got data %h strb %b last %b expected data %h strb %b last 1",
                       a, bus.WDATA, bus.WSTRB, bus.WLAST, b.data, b.strb);
            end
          end else begin
            bus.WREADY = 1'b0;
            wc++;
          end
        end else begin
          bus.WREADY = 1'b0;
        end
        if (bus.BREADY) begin
          if (bc >= b_wait) begin
            bus.BVALID = 1'b1;
            bus.BRESP  = resp;
            b_hs++;
          end else begin
            bus.BVALID = 1'b0;
            bc++;
          end
        end else begin
          bus.BVALID = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end else begin
        done = 1;
        bus.AWREADY  = 1'b0;
        bus.WREADY   = 1'b0;
        bus.BVALID   = 1'b0;
        mem_memwrite = 1'b0;
        mem_memread  = 1'b0;
        checks++;
        if (stall_cnt != exp_stall) begin
          errors++;
          $display("FAIL store_stall_cycles addr %h: got %0d expected %0d", a, stall_cnt, exp_stall);
        end
        checks++;
        if (b_hs != 1 || !aw_hs || !w_hs || ar_seen) begin
          errors++;
          $display("FAIL store_handshakes addr %h: got b %0d aw %0d w %0d ar %0d expected b 1 aw 1 w 1 ar 0",
                   a, b_hs, aw_hs, w_hs, ar_seen);
        end
        checks++;
        if (rdata_out !== last_load) begin
          errors++;
          $display("FAIL rdata_hold addr %h: got %h expected %h", a, rdata_out, last_load);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL store_timeout addr %h: got no completion expected completion within 60 cycles", a);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      last_load = 32'd0;
      @(negedge clk);
    end
  endtask

  task automatic test_word_load();
    do_load(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 0, 0, 2'b00, 32'hDEAD_BEEF, 3);
    do_load(32'h0000_0208, 1'b1, 32'h1357_9BDF, 1, 2, 2'b00, 32'h1357_9BDF, 6);
  endtask

  task automatic test_byte_load();
    do_load(32'h0000_0103, 1'b0, 32'h80FF_0000, 0, 0, 2'b00, 32'hFFFF_FF80, 3);
    do_load(32'h0000_0101, 1'b0, 32'h0000_7F00, 2, 1, 2'b00, 32'h0000_007F, 6);
    do_load(32'h0000_0200, 1'b0, 32'h1234_5678, 0, 0, 2'b00, 32'h0000_0078, 3);
    do_load(32'h0000_0206, 1'b0, 32'h00AB_0000, 0, 0, 2'b00, 32'hFFFF_FFAB, 3);
  endtask

  task automatic test_stores();
    do_store(32'h0000_0102, 1'b0, 32'h0000_00AB, 1'b0, 0, 0, 0, 2'b00, 4'b0100, 32'hABAB_ABAB, 3);
    do_store(32'h0000_0200, 1'b1, 32'h1234_5678, 1'b0, 1, 0, 2, 2'b00, 4'b1111, 32'h1234_5678, 6);
  endtask

  task automatic test_split_write();
    do_store(32'h0000_0101, 1'b0, 32'h1234_56C3, 1'b0, 0, 3, 0, 2'b00, 4'b0010, 32'hC3C3_C3C3, 6);
    do_store(32'h0000_0003, 1'b0, 32'h0000_005A, 1'b0, 2, 0, 0, 2'b00, 4'b1000, 32'h5A5A_5A5A, 5);
  endtask

  task automatic test_back_to_back();
    do_store(32'h0000_0204, 1'b1, 32'h0BAD_F00D, 1'b1, 0, 0, 0, 2'b00, 4'b1111, 32'h0BAD_F00D, 3);
    do_load(32'h0000_0204, 1'b1, 32'h0BAD_F00D, 0, 0, 2'b00, 32'h0BAD_F00D, 3);
    do_store(32'h0000_0205, 1'b0, 32'h0000_0011, 1'b0, 0, 0, 0, 2'b00, 4'b0010, 32'h1111_1111, 3);
  endtask

  task automatic test_bus_err();
    logic exp_err;
`ifdef DMEM_ERR_FLAG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL bus_err_before: got %b expected 0", bus_err);
    end
    do_store(32'h0000_0300, 1'b1, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 2'b10, 4'b1111, 32'hCAFE_F00D, 3);
    checks++;
    if (bus_err !== exp_err) begin
      errors++;
      $display("FAIL bus_err_set: got %b expected %b", bus_err, exp_err);
    end
    do_load(32'h0000_0300, 1'b1, 32'h2468_ACE0, 0, 0, 2'b00, 32'h2468_ACE0, 3);
    checks++;
    if (bus_err !== exp_err) begin
      errors++;
      $display("FAIL bus_err_sticky: got %b expected %b", bus_err, exp_err);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL bus_err_rst_clear: got %b expected 0", bus_err);
    end
    rst = 1'b0;
    last_load = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int cyc = 0;
    bit hit = 0;
    do_load(32'h0000_0110, 1'b1, 32'h7654_3210, 0, 0, 2'b00, 32'h7654_3210, 3);
    mem_memread = 1'b1;
    addr        = 32'h0000_0104;
    ls_word     = 1'b1;
    while (!hit && cyc < 20) begin
      #1;
      if (bus.RREADY) begin
        hit = 1;
      end else begin
        bus.ARREADY = bus.ARVALID;
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_reach_rd_data: got no RREADY expected RREADY within 20 cycles");
    end
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.ARVALID, bus.RREADY, stall} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got arvalid %b rready %b stall %b expected 000", bus.ARVALID, bus.RREADY, stall);
    end
    checks++;
    if (rdata_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_rdata: got %h expected 00000000", rdata_out);
    end
    rst = 1'b0;
    last_load = 32'd0;
    @(negedge clk);
    do_load(32'h0000_0104, 1'b1, 32'h55AA_55AA, 0, 0, 2'b00, 32'h55AA_55AA, 3);
  endtask

  initial begin
    rst          = 1'b1;
    addr         = 32'd0;
    wdata_in     = 32'd0;
    ls_word      = 1'b0;
    idle_inputs();
    bus.RDATA    = 32'd0;
    bus.RRESP    = 2'b00;
    bus.RID      = MID;
    bus.RLAST    = 1'b1;
    bus.BRESP    = 2'b00;
    bus.BID      = MID;

    test_reset();
    test_word_load();
    test_byte_load();
    test_stores();
    test_split_write();
    test_back_to_back();
    test_bus_err();
    test_rst_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
